coin_acceptor: RTL and testbench



---
 rtl/coin_acceptor.sv | 127 ++++++++++++
 tb/tb_coin_acceptor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin sensor front end: two-flop synchronisers, debounce FSM and one pulse per physical coin.
// in50/in100/coin_reject/coin_err are one-cycle events with no back-pressure; the consumer samples them every cycle.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin50_raw,
  input  logic             coin100_raw,
  input  logic             accept_en,
  output logic             in50,
  output logic             in100,
  output logic             coin_reject,
  output logic             coin_err,
  output logic [CNT_W-1:0] coins_accepted,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("coin_acceptor: DEBOUNCE_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync1_q, sync2_q;
  logic [1:0] pat_q, pat_d;
  logic [7:0] cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic       in50_d, in100_d, reject_d, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {coin100_raw, coin50_raw};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    in50_d   = 1'b0;
    in100_d  = 1'b0;
    reject_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q != 2'b00) begin
          state_d = DEBOUNCE;
          pat_d   = sync2_q;
          cnt_d   = 8'd1;
        end
      end
      DEBOUNCE: begin
        if (sync2_q == 2'b00) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (sync2_q != pat_q) begin
          pat_d = sync2_q;
          cnt_d = 8'd1;
        end else if (cnt_q == LAST) begin
          // Qualify edge: the only point where accept_en matters.
          state_d = RELEASE;
          cnt_d   = 8'd0;
          if (pat_q == 2'b11) err_d = 1'b1;
          else if (!accept_en) reject_d = 1'b1;
          else if (pat_q == 2'b01) in50_d = 1'b1;
          else in100_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        if (sync2_q != 2'b00) begin
          cnt_d = 8'd0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      pat_q          <= 2'b00;
      in50           <= 1'b0;
      in100          <= 1'b0;
      coin_reject    <= 1'b0;
      coin_err       <= 1'b0;
      coins_accepted <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      in50        <= in50_d;
      in100       <= in100_d;
      coin_reject <= reject_d;
      coin_err    <= err_d;
      if ((in50_d || in100_d) && (coins_accepted != {CNT_W{1'b1}}))
        coins_accepted <= coins_accepted + CNT_W'(1);
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed vector table, hand-written corner sequences and random
// sensor activity checked against a run-length reference model of the debounce rules.
module tb_coin_acceptor;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin50_raw = 1'b0;
  logic       coin100_raw = 1'b0;
  logic       accept_en = 1'b0;
  logic       in50, in100, coin_reject, coin_err, busy;
  logic [7:0] coins_accepted;
  logic [1:0] state_dbg;
  logic       s_in50, s_in100, s_rej, s_err, s_busy;
  logic [1:0] s_cnt, s_state;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .coin50_raw(coin50_raw), .coin100_raw(coin100_raw),
    .accept_en(accept_en), .in50(in50), .in100(in100), .coin_reject(coin_reject),
    .coin_err(coin_err), .coins_accepted(coins_accepted), .busy(busy), .state_dbg(state_dbg)
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .coin50_raw(coin50_raw), .coin100_raw(coin100_raw),
    .accept_en(accept_en), .in50(s_in50), .in100(s_in100), .coin_reject(s_rej),
    .coin_err(s_err), .coins_accepted(s_cnt), .busy(s_busy), .state_dbg(s_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int step_idx = 0;
  int n50 = 0, n100 = 0, nrej = 0, nerr = 0;
  int last_pulse = -1;

  // Reference model: sensor history plus run lengths of the synchronised pattern.
  logic [1:0] h1, h2;
  bit         m_armed;
  logic [1:0] m_pat;
  int         m_run, m_zero, m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0h, want %0h", name, step_idx, act, exp);
    end
  endtask

  task automatic model_reset();
    h1 = 2'b00; h2 = 2'b00;
    m_armed = 1'b1; m_pat = 2'b00; m_run = 0; m_zero = 0; m_count = 0;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    #1;
    check("reset_outputs", {19'd0, in50, in100, coin_reject, coin_err, busy, coins_accepted},
          32'd0);
    check("reset_state", {28'd0, state_dbg, s_cnt}, 32'd0);
    model_reset();
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input logic c50, input logic c100, input logic acc);
    logic [1:0] p;
    logic e50, e100, erej, eerr, ebusy;
    logic [7:0] ecnt;
    int sat;
    coin50_raw = c50; coin100_raw = c100; accept_en = acc;
    @(posedge clk);
    #1;
    p = h2; h2 = h1; h1 = {c100, c50};
    e50 = 1'b0; e100 = 1'b0; erej = 1'b0; eerr = 1'b0;
    if (m_armed) begin
      if (p == 2'b00) begin
        m_run = 0; m_pat = 2'b00;
      end else if (p == m_pat) begin
        m_run++;
      end else begin
        m_pat = p; m_run = 1;
      end
      if (m_run == D) begin
        if (p == 2'b11) eerr = 1'b1;
        else if (!acc) erej = 1'b1;
        else if (p == 2'b01) e50 = 1'b1;
        else e100 = 1'b1;
        m_armed = 1'b0; m_zero = 0; m_run = 0;
      end
    end else begin
      m_zero = (p == 2'b00) ? m_zero + 1 : 0;
      if (m_zero == D) begin
        m_armed = 1'b1; m_run = 0; m_pat = 2'b00;
      end
    end
    if (e50 || e100) m_count++;
    ebusy = !m_armed || (m_run > 0);
    ecnt = (m_count > 255) ? 8'd255 : 8'(m_count);
    sat = (m_count > 3) ? 3 : m_count;
    check("model", {19'd0, in50, in100, coin_reject, coin_err, busy, coins_accepted},
          {19'd0, e50, e100, erej, eerr, ebusy, ecnt});
    check("sat_count", {30'd0, s_cnt}, 32'(sat));
    if (in50) n50++;
    if (in100) n100++;
    if (coin_reject) nrej++;
    if (coin_err) nerr++;
    if (in50 || in100 || coin_reject || coin_err) last_pulse = step_idx;
    step_idx++;
  endtask

  task automatic coin(input logic c50, input logic c100, input logic acc, input int hold);
    for (int i = 0; i < hold; i++) step(c50, c100, acc);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, acc);
  endtask

  typedef struct {
    logic       c50;
    logic       c100;
    logic       acc;
    logic [4:0] exp_flags;  // {in50, in100, coin_reject, coin_err, busy}
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int base, b50, b100, brej, berr, bcnt;
    logic [5:0] bounce;
    logic [1:0] pat;
    int len;

    // First 50 coin: raw high for edges 0..9, pulse after edge 5, busy low after edge 15.
    for (int i = 0; i < 16; i++) begin
      tbl[i].c50       = (i < 10);
      tbl[i].c100      = 1'b0;
      tbl[i].acc       = 1'b1;
      tbl[i].exp_flags = {(i == 5), 1'b0, 1'b0, 1'b0, (i >= 2 && i < 15)};
      tbl[i].exp_cnt   = (i >= 5) ? 8'd1 : 8'd0;
    end

    model_reset();
    #2;
    apply_reset(3);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].c50, tbl[i].c100, tbl[i].acc);
      check("vector", {19'd0, in50, in100, coin_reject, coin_err, busy, coins_accepted},
            {19'd0, tbl[i].exp_flags, tbl[i].exp_cnt});
    end

    // Bouncing 100 coin; the trailing 1 of the bounce joins the stable run starting at offset 5.
    b100 = n100; bcnt = coins_accepted; base = step_idx;
    bounce = 6'b101101;
    for (int i = 0; i < 6; i++) step(1'b0, bounce[5-i], 1'b1);
    coin(1'b0, 1'b1, 1'b1, 8);
    check("bounce_pulses", 32'(n100 - b100), 32'd1);
    check("bounce_latency", 32'(last_pulse - base), 32'd10);
    check("bounce_count", {24'd0, coins_accepted}, 32'(bcnt + 1));

    // Single-cycle glitch.
    b50 = n50; b100 = n100; brej = nrej; berr = nerr; bcnt = coins_accepted;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    check("glitch_pulses", 32'(n50 + n100 + nrej + nerr - b50 - b100 - brej - berr), 32'd0);
    check("glitch_idle", {31'd0, busy}, 32'd0);
    check("glitch_count", {24'd0, coins_accepted}, 32'(bcnt));

    // Both sensors together.
    b50 = n50; b100 = n100; berr = nerr; bcnt = coins_accepted;
    coin(1'b1, 1'b1, 1'b1, 8);
    check("both_err", 32'(nerr - berr), 32'd1);
    check("both_no_coin", 32'(n50 + n100 - b50 - b100), 32'd0);
    check("both_count", {24'd0, coins_accepted}, 32'(bcnt));

    // Rejected coin, then an accepted one with accept_en toggling during release.
    b50 = n50; brej = nrej;
    coin(1'b1, 1'b0, 1'b0, 6);
    check("reject_pulse", 32'(nrej - brej), 32'd1);
    check("reject_no_in50", 32'(n50 - b50), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'(i % 2));
    check("accept_after_reject", 32'(n50 - b50), 32'd1);

    // Reset while DEBOUNCE holds cnt = 2, sensor still high.
    b50 = n50;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    check("pre_reset_busy", {30'd0, state_dbg}, 32'd1);
    apply_reset(2);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    check("reset_drop_coin", 32'(n50 - b50), 32'd0);

    // Saturation of the 2-bit counter after five coins.
    apply_reset(2);
    for (int k = 0; k < 5; k++) coin(1'(k % 2 == 0), 1'(k % 2 == 1), 1'b1, 6);
    check("sat_at_3", {30'd0, s_cnt}, 32'd3);
    check("wide_at_5", {24'd0, coins_accepted}, 32'd5);

    // Random sensor activity against the model.
    apply_reset(2);
    for (int seg = 0; seg < 150; seg++) begin
      pat = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) step(pat[0], pat[1], 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
